// File: rtl/transpad_arb.sv
// transpad_arb: round-robin session arbiter in front of the transpad control unit.
// Optional timeout supervision enabled with `define TRANSPAD_ARB_TMO_EN.
module transpad_arb #(
    parameter int NREQ  = 4,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  rel,
    input  logic             cu_idle,
    input  logic             act,
    input  logic [TMO_W-1:0] tmo_lim,
    output logic             start_req_ok,
    output logic             stop_req,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             tmo_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_STOP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     own_q, own_d;
    logic [IW-1:0]     last_q, last_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;
    logic              stop_q, stop_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              tmo_err_q, tmo_err_d;
    logic              tmo_hit;
    logic              win_vld;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     cand;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base,
                                             input int k);
        return IW'((int'(base) + k) % NREQ);
    endfunction

    // Round-robin pick: first requester after the previous owner, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = rr_idx(last_q, k);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

`ifdef TRANSPAD_ARB_TMO_EN
    logic [TMO_W-1:0] cnt_q, cnt_d;

    // Count act cycles within a session; compare the incremented value so a
    // limit of N stops the session right after the N-th active cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_START) begin
            cnt_d = '0;
        end else if (state_q == S_RUN && act && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
        tmo_hit = (state_q == S_RUN) && (tmo_lim != '0) && (cnt_d >= tmo_lim);
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_tmo;

    // Without supervision the limit and activity inputs have no effect.
    always_comb begin
        tmo_hit    = 1'b0;
        unused_tmo = ^{tmo_lim, act};
    end
`endif

    // Session sequencing and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        own_d     = own_q;
        last_d    = last_q;
        busy_d    = busy_q;
        tmo_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cu_idle && win_vld) begin
                    state_d = S_START;
                    gnt_d   = NREQ'(1) << win_idx;
                    own_d   = win_idx;
                end
            end
            S_START: begin
                busy_d  = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!cu_idle) begin
                    busy_d = 1'b1;
                end
                if (cu_idle && busy_q) begin
                    state_d = S_DONE;
                end else if (rel[own_q] || tmo_hit) begin
                    state_d   = S_STOP;
                    tmo_err_d = tmo_hit;
                end
            end
            S_STOP: begin
                if (!cu_idle) begin
                    busy_d = 1'b1;
                end
                if (cu_idle && busy_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = own_q;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        start_d = (state_d == S_START);
        stop_d  = (state_d == S_STOP);
        done_d  = (state_d == S_DONE) ? gnt_d : '0;
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            own_q     <= '0;
            last_q    <= IW'(NREQ - 1);
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            own_q     <= own_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign start_req_ok = start_q;
    assign stop_req     = stop_q;
    assign gnt          = gnt_q;
    assign done         = done_q;
    assign tmo_err      = tmo_err_q;

endmodule

// File: tb/tb_transpad_arb.sv
// tb_transpad_arb: randomized self-checking bench for transpad_arb.
// Timeout scenarios follow the TRANSPAD_ARB_TMO_EN build option.
module tb_transpad_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic [3:0]  rel;
    logic        cu_idle;
    logic        act;
    logic [15:0] tmo_lim;
    logic        start_req_ok;
    logic        stop_req;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        tmo_err;

    int checks   = 0;
    int failures = 0;
    int last_m   = 3;

    transpad_arb #(.NREQ(4), .TMO_W(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req          (req),
        .rel          (rel),
        .cu_idle      (cu_idle),
        .act          (act),
        .tmo_lim      (tmo_lim),
        .start_req_ok (start_req_ok),
        .stop_req     (stop_req),
        .gnt          (gnt),
        .done         (done),
        .tmo_err      (tmo_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference rule: first set request after the last owner, modulo 4.
    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0001;
        return (i < 0) ? 4'b0000 : (v << i);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rstn    = 1'b0;
        req     = '0;
        rel     = '0;
        cu_idle = 1'b1;
        act     = 1'b0;
        tmo_lim = '0;
        repeat (2) tick();
        rstn   = 1'b1;
        last_m = 3;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if ({start_req_ok, stop_req, gnt, done, tmo_err} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0",
                     {start_req_ok, stop_req, gnt, done, tmo_err});
        end
    endtask

    task automatic test_basic;
        logic bad;
        apply_reset();
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || start_req_ok !== 1'b1) begin
            failures++;
            $display("FAIL basic_grant gnt=%b start=%b want 0001/1", gnt, start_req_ok);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (start_req_ok !== 1'b0) begin
            failures++;
            $display("FAIL basic_start_pulse start=%b want 0", start_req_ok);
        end
        cu_idle = 1'b0;
        act     = 1'b1;
        bad     = 1'b0;
        repeat (10) begin
            tick();
            if (done !== 4'b0000 || gnt !== 4'b0001 || stop_req !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL basic_busy_hold got_bad=1 want 0");
        end
        cu_idle = 1'b1;
        act     = 1'b0;
        tick();
        checks++;
        if (done !== 4'b0001) begin
            failures++;
            $display("FAIL basic_done done=%b want 0001", done);
        end
        tick();
        checks++;
        if (gnt !== 4'b0000 || done !== 4'b0000) begin
            failures++;
            $display("FAIL basic_release gnt=%b done=%b want 0000/0000", gnt, done);
        end
        last_m = 0;
    endtask

    task automatic test_back_to_back;
        int         exp;
        int         n;
        int         starts;
        logic       bad;
        apply_reset();
        req = 4'b1111;
        tick();
        for (int s = 0; s < 4; s++) begin
            exp = rr_pick(last_m, req);
            checks++;
            if (gnt !== oh(exp) || start_req_ok !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant s=%0d gnt=%b start=%b want %b/1",
                         s, gnt, start_req_ok, oh(exp));
            end
            starts = 1;
            bad    = 1'b0;
            tick();
            cu_idle = 1'b0;
            act     = 1'b1;
            repeat ($urandom_range(8, 3)) begin
                tick();
                if (start_req_ok) starts++;
                if (gnt !== oh(exp) || !$onehot(gnt)) bad = 1'b1;
            end
            cu_idle = 1'b1;
            act     = 1'b0;
            tick();
            checks++;
            if (done !== oh(exp) || starts != 1 || bad) begin
                failures++;
                $display("FAIL rr_session s=%0d done=%b starts=%0d bad=%b want %b/1/0",
                         s, done, starts, bad, oh(exp));
            end
            last_m = exp;
            if (s < 3) begin
                n = 0;
                do begin
                    tick();
                    n++;
                end while (gnt === 4'b0000 && n < 6);
                checks++;
                if (n != 2) begin
                    failures++;
                    $display("FAIL rr_gap s=%0d gap=%0d want 2", s, n);
                end
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_release;
        logic bad;
        apply_reset();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== oh(rr_pick(last_m, 4'b0100))) begin
            failures++;
            $display("FAIL rel_grant gnt=%b want 0100", gnt);
        end
        req = 4'b0000;
        tick();
        cu_idle = 1'b0;
        act     = 1'b1;
        repeat (3) tick();
        rel = 4'b0100;
        tick();
        rel = 4'b0000;
        checks++;
        if (stop_req !== 1'b1 || done !== 4'b0000) begin
            failures++;
            $display("FAIL rel_stop stop=%b done=%b want 1/0000", stop_req, done);
        end
        bad = 1'b0;
        repeat (2) begin
            tick();
            if (stop_req !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rel_stop_hold bad=1 want 0");
        end
        cu_idle = 1'b1;
        act     = 1'b0;
        tick();
        checks++;
        if (stop_req !== 1'b0 || done !== 4'b0100 || tmo_err !== 1'b0) begin
            failures++;
            $display("FAIL rel_done stop=%b done=%b tmo=%b want 0/0100/0",
                     stop_req, done, tmo_err);
        end
        tick();
        last_m = 2;
    endtask

    task automatic test_timeout;
        int   stops;
        logic bad;
        apply_reset();
        tmo_lim = 16'd5;
        req     = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        cu_idle = 1'b0;
        act     = 1'b1;
`ifdef TRANSPAD_ARB_TMO_EN
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (stop_req !== 1'b0 || tmo_err !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL tmo_early stop before limit");
        end
        tick();
        checks++;
        if (stop_req !== 1'b1 || tmo_err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_hit stop=%b tmo=%b want 1/1", stop_req, tmo_err);
        end
        tick();
        checks++;
        if (stop_req !== 1'b1 || tmo_err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_pulse stop=%b tmo=%b want 1/0", stop_req, tmo_err);
        end
        cu_idle = 1'b1;
        act     = 1'b0;
        tick();
        checks++;
        if (done !== 4'b0001 || stop_req !== 1'b0) begin
            failures++;
            $display("FAIL tmo_done done=%b stop=%b want 0001/0", done, stop_req);
        end
        tick();
        tmo_lim = 16'd0;
        req     = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        cu_idle = 1'b0;
        act     = 1'b1;
        stops   = 0;
        repeat (100) begin
            tick();
            if (stop_req || tmo_err) stops++;
        end
`else
        stops = 0;
        repeat (40) begin
            tick();
            if (stop_req || tmo_err) stops++;
        end
`endif
        checks++;
        if (stops != 0) begin
            failures++;
            $display("FAIL tmo_none stop_cycles=%0d want 0", stops);
        end
        cu_idle = 1'b1;
        act     = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_cu_busy;
        logic bad;
        apply_reset();
        cu_idle = 1'b0;
        req     = 4'b0001;
        bad     = 1'b0;
        repeat (5) begin
            tick();
            if (gnt !== 4'b0000 || start_req_ok !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL cu_busy_nogrant bad=1 want 0");
        end
        cu_idle = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0001 || start_req_ok !== 1'b1) begin
            failures++;
            $display("FAIL cu_busy_grant gnt=%b start=%b want 0001/1", gnt, start_req_ok);
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_stop;
        apply_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        cu_idle = 1'b0;
        act     = 1'b1;
        tick();
        rel = 4'b0001;
        tick();
        rel = 4'b0000;
        checks++;
        if (stop_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_stop_entry stop=%b want 1", stop_req);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({start_req_ok, stop_req, gnt, done, tmo_err} !== 11'd0) begin
            failures++;
            $display("FAIL rst_async got=%b want 0",
                     {start_req_ok, stop_req, gnt, done, tmo_err});
        end
        #1;
        rstn    = 1'b1;
        last_m  = 3;
        cu_idle = 1'b1;
        act     = 1'b0;
        req     = 4'b0010;
        tick();
        checks++;
        if (gnt !== oh(rr_pick(last_m, 4'b0010)) || start_req_ok !== 1'b1) begin
            failures++;
            $display("FAIL rst_regrant gnt=%b start=%b want 0010/1", gnt, start_req_ok);
        end
        req = 4'b0000;
    endtask

    task automatic test_random;
        logic [3:0] r;
        logic [3:0] expg;
        int         exp;
        int         mode;
        logic       bad;
        apply_reset();
        for (int s = 0; s < 30; s++) begin
            r = 4'($urandom_range(15, 1));
            req = r;
            rel = '0;
            exp = rr_pick(last_m, r);
            expg = oh(exp);
            tick();
            checks++;
            if (gnt !== expg || start_req_ok !== 1'b1) begin
                failures++;
                $display("FAIL rnd_grant s=%0d req=%b gnt=%b want %b", s, r, gnt, expg);
            end
            bad = 1'b0;
            tick();
            mode    = $urandom_range(2, 0);
            cu_idle = 1'b0;
            act     = 1'b1;
            repeat ($urandom_range(6, 1)) begin
                req = 4'($urandom);
                rel = 4'($urandom) & ~expg;
                tick();
                if (gnt !== expg || stop_req !== 1'b0 || done !== 4'b0000) bad = 1'b1;
            end
            rel = 4'($urandom) & ~expg;
            if (mode == 1) begin
                rel = rel | expg;
                tick();
                rel = 4'($urandom) & ~expg;
                if (stop_req !== 1'b1 || done !== 4'b0000) bad = 1'b1;
                repeat ($urandom_range(3, 1)) begin
                    tick();
                    if (stop_req !== 1'b1 || gnt !== expg) bad = 1'b1;
                end
            end else if (mode == 2) begin
                rel = rel | expg;
            end
            cu_idle = 1'b1;
            act     = 1'b0;
            tick();
            checks++;
            if (done !== expg || stop_req !== 1'b0 || tmo_err !== 1'b0 || bad) begin
                failures++;
                $display("FAIL rnd_session s=%0d mode=%0d done=%b stop=%b tmo=%b bad=%b want %b/0/0/0",
                         s, mode, done, stop_req, tmo_err, bad, expg);
            end
            last_m = exp;
            req    = '0;
            rel    = '0;
            tick();
            checks++;
            if (gnt !== 4'b0000 || done !== 4'b0000) begin
                failures++;
                $display("FAIL rnd_idle s=%0d gnt=%b done=%b want 0000/0000", s, gnt, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_release();
        test_timeout();
        test_cu_busy();
        test_reset_mid_stop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
